// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control token encodings, receive alignment states
// and the token lookup used by both the encoder and decoder paths.
package tmds_pkg;

   localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
   localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
   localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
   localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

   typedef enum logic [1:0] {SEARCH, WAIT, LOCKED} tmds_align_state_e;

   // Returns {is_ctrl, ctrl[1:0]}; ctrl is 0 for data symbols.
   function automatic logic [2:0] tmds_ctrl_lookup(input logic [9:0] symbol);
      logic [2:0] result;
      case (symbol)
         TMDS_CTRL_00: result = 3'b1_00;
         TMDS_CTRL_01: result = 3'b1_01;
         TMDS_CTRL_10: result = 3'b1_10;
         TMDS_CTRL_11: result = 3'b1_11;
         default:      result = 3'b0_00;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: undoes the DC-balance inversion and the
// XOR/XNOR transition coding, and flags the four control tokens.
module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [9:0] symbol_i,
   output logic       is_ctrl_o,
   output logic [1:0] ctrl_o,
   output logic [7:0] data_o
);

   logic [7:0] d;

   // NOTE: every combinational output gets a value on every path, so no latch is inferred.
   always_comb begin
      d         = symbol_i[9] ? ~symbol_i[7:0] : symbol_i[7:0];
      data_o    = 8'h00;
      data_o[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         data_o[i] = symbol_i[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
      {is_ctrl_o, ctrl_o} = tmds_ctrl_lookup(symbol_i);
   end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive lane: word alignment by bitslip while hunting for runs of
// control tokens, plus registered decode of pixel data / control values.
module tmds_channel_decoder
   import tmds_pkg::*;
#(
   parameter int CtrlRunLen    = 8,
   parameter int SearchTimeout = 1024,
   parameter int SlipWait      = 4,
   parameter int LossTimeout   = 4096
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [9:0] tmds_i,
   output logic       bitslip_o,
   output logic       locked_o,
   output logic [3:0] slip_cnt_o,
   output logic       de_o,
   output logic [7:0] data_o,
   output logic [1:0] ctrl_o
);

   localparam int RunW  = $clog2(CtrlRunLen + 1);
   localparam int ToW   = $clog2(SearchTimeout + 1);
   localparam int WaitW = $clog2(SlipWait + 1);
   localparam int LossW = $clog2(LossTimeout + 1);

   tmds_align_state_e state_q, state_d;
   logic [RunW-1:0]   run_q, run_d;
   logic [ToW-1:0]    to_q, to_d;
   logic [WaitW-1:0]  wait_q, wait_d;
   logic [LossW-1:0]  loss_q, loss_d;
   logic [3:0]        slip_cnt_q, slip_cnt_d;
   logic              bitslip_q, bitslip_d;
   logic              de_q, de_d;
   logic [7:0]        data_q, data_d;
   logic [1:0]        ctrl_q, ctrl_d;

   logic       is_ctrl;
   logic [1:0] sym_ctrl;
   logic [7:0] sym_data;

   tmds_symbol_decode u_decode (
      .symbol_i  (tmds_i),
      .is_ctrl_o (is_ctrl),
      .ctrl_o    (sym_ctrl),
      .data_o    (sym_data)
   );

   always_comb begin
      state_d    = state_q;
      run_d      = run_q;
      to_d       = to_q;
      wait_d     = wait_q;
      loss_d     = loss_q;
      slip_cnt_d = slip_cnt_q;
      bitslip_d  = 1'b0;

      case (state_q)
         SEARCH: begin
            to_d  = to_q + ToW'(1);
            run_d = !is_ctrl ? '0 :
                    (run_q == RunW'(CtrlRunLen)) ? run_q : run_q + RunW'(1);
            // Lock takes priority over a coincident timeout.
            if (is_ctrl && run_q == RunW'(CtrlRunLen - 1)) begin
               state_d    = LOCKED;
               slip_cnt_d = '0;
               run_d      = '0;
               to_d       = '0;
               loss_d     = '0;
            end else if (to_q == ToW'(SearchTimeout - 1)) begin
               state_d    = WAIT;
               bitslip_d  = 1'b1;
               slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
               run_d      = '0;
               to_d       = '0;
               wait_d     = '0;
            end
         end
         WAIT: begin
            wait_d = wait_q + WaitW'(1);
            if (wait_q == WaitW'(SlipWait - 1)) begin
               state_d = SEARCH;
               wait_d  = '0;
               run_d   = '0;
               to_d    = '0;
            end
         end
         LOCKED: begin
            if (is_ctrl) begin
               loss_d = '0;
            end else if (loss_q == LossW'(LossTimeout - 1)) begin
               state_d = SEARCH;
               loss_d  = '0;
               run_d   = '0;
               to_d    = '0;
            end else begin
               loss_d = loss_q + LossW'(1);
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   // Output gating follows the next state so the decoded outputs agree with locked_o.
   always_comb begin
      de_d   = de_q;
      data_d = data_q;
      ctrl_d = ctrl_q;
      if (state_d != LOCKED) begin
         de_d   = 1'b0;
         data_d = 8'h00;
         ctrl_d = 2'b00;
      end else if (is_ctrl) begin
         de_d   = 1'b0;
         ctrl_d = sym_ctrl;
      end else begin
         de_d   = 1'b1;
         data_d = sym_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= SEARCH;
         run_q      <= '0;
         to_q       <= '0;
         wait_q     <= '0;
         loss_q     <= '0;
         slip_cnt_q <= '0;
         bitslip_q  <= 1'b0;
         de_q       <= 1'b0;
         data_q     <= 8'h00;
         ctrl_q     <= 2'b00;
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         to_q       <= to_d;
         wait_q     <= wait_d;
         loss_q     <= loss_d;
         slip_cnt_q <= slip_cnt_d;
         bitslip_q  <= bitslip_d;
         de_q       <= de_d;
         data_q     <= data_d;
         ctrl_q     <= ctrl_d;
      end
   end

   assign bitslip_o  = bitslip_q;
   assign locked_o   = (state_q == LOCKED);
   assign slip_cnt_o = slip_cnt_q;
   assign de_o       = de_q;
   assign data_o     = data_q;
   assign ctrl_o     = ctrl_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed self-checking bench for the TMDS lane decoder: reset, lock, decode,
// bitslip hunting, loss of lock and reset during WAIT.
module tb_tmds_channel_decoder;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [9:0] tmds_i;
   logic       bitslip_o;
   logic       locked_o;
   logic [3:0] slip_cnt_o;
   logic       de_o;
   logic [7:0] data_o;
   logic [1:0] ctrl_o;

   int   n_checks    = 0;
   int   n_fail      = 0;
   int   slip_pulses = 0;
   int   dbl_pulses  = 0;
   logic prev_slip   = 1'b0;
   int   n;

   always #5 clk_i = ~clk_i;

   tmds_channel_decoder dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .tmds_i     (tmds_i),
      .bitslip_o  (bitslip_o),
      .locked_o   (locked_o),
      .slip_cnt_o (slip_cnt_o),
      .de_o       (de_o),
      .data_o     (data_o),
      .ctrl_o     (ctrl_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Drive one symbol, clock it in, sample 1 time unit after the edge.
   task automatic step(input logic [9:0] sym);
      tmds_i = sym;
      @(posedge clk_i);
      #1;
      if (bitslip_o === 1'b1) begin
         slip_pulses++;
         if (prev_slip) dbl_pulses++;
      end
      prev_slip = (bitslip_o === 1'b1);
   endtask

   // Steps with a fixed symbol until a bitslip pulse; returns steps taken or -1.
   task automatic run_to_slip(input logic [9:0] sym, input int budget, output int steps);
      steps = -1;
      for (int i = 1; i <= budget; i++) begin
         if (steps < 0) begin
            step(sym);
            if (bitslip_o === 1'b1) steps = i;
         end
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "/bitslip"}, 32'(bitslip_o), 0);
      check({tag, "/locked"}, 32'(locked_o), 0);
      check({tag, "/slip_cnt"}, 32'(slip_cnt_o), 0);
      check({tag, "/de"}, 32'(de_o), 0);
      check({tag, "/data"}, 32'(data_o), 0);
      check({tag, "/ctrl"}, 32'(ctrl_o), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with random symbols, then search with no tokens.
      rst_i = 1'b1;
      step(10'($urandom));
      step(10'($urandom));
      check_idle("reset");
      rst_i = 1'b0;
      run_to_slip(10'h100, 1100, n);
      check("first_slip_delay", n, 1024);
      check("first_slip_cnt", 32'(slip_cnt_o), 1);
      check("first_slip_locked", 32'(locked_o), 0);
      step(10'h100);
      check("slip_width", 32'(bitslip_o), 0);
      repeat (5) step(10'h100);

      // Lock on a run of 8 CTRL_00 tokens.
      repeat (7) step(10'h354);
      check("lock_after_7", 32'(locked_o), 0);
      step(10'h354);
      check("lock_after_8", 32'(locked_o), 1);
      check("lock_de", 32'(de_o), 0);
      check("lock_ctrl", 32'(ctrl_o), 0);
      check("lock_slip_cnt", 32'(slip_cnt_o), 0);
      step(10'h2AB);
      check("ctrl11", 32'(ctrl_o), 3);
      check("ctrl11_de", 32'(de_o), 0);

      // Data decode and hold behaviour.
      step(10'h100);
      check("data_100_de", 32'(de_o), 1);
      check("data_100", 32'(data_o), 32'h00);
      step(10'h200);
      check("data_200", 32'(data_o), 32'hFF);
      check("ctrl_hold", 32'(ctrl_o), 3);
      step(10'h0AB);
      check("ctrl01", 32'(ctrl_o), 1);
      check("ctrl01_de", 32'(de_o), 0);
      check("data_hold", 32'(data_o), 32'hFF);

      // Loss of lock: one token at LossTimeout-2 keeps lock, then a full run drops it.
      slip_pulses = 0;
      for (int i = 0; i < 4096; i++) step((i == 4094) ? 10'h354 : 10'h100);
      check("loss_saved", 32'(locked_o), 1);
      check("loss_saved_de", 32'(de_o), 1);
      repeat (4094) step(10'h100);
      check("loss_before", 32'(locked_o), 1);
      step(10'h100);
      check("loss_dropped", 32'(locked_o), 0);
      check("loss_de", 32'(de_o), 0);
      check("loss_data", 32'(data_o), 0);
      check("loss_no_slip", slip_pulses, 0);

      // Misaligned stream: ten slips, slip count wraps 9 -> 0.
      slip_pulses = 0;
      dbl_pulses  = 0;
      for (int s = 1; s <= 10; s++) begin
         run_to_slip(10'h2A9, 1100, n);
         check($sformatf("slip%0d_gap", s), n, (s == 1) ? 1024 : 1028);
         check($sformatf("slip%0d_cnt", s), 32'(slip_cnt_o), s % 10);
      end
      check("slip_total", slip_pulses, 10);
      check("slip_single_cycle", dbl_pulses, 0);
      repeat (50) step(10'h2A9);
      repeat (8) step(10'h354);
      check("relock", 32'(locked_o), 1);
      check("relock_slip_cnt", 32'(slip_cnt_o), 0);

      // Broken run: 7 tokens, one data symbol, 8 tokens.
      rst_i = 1'b1;
      step(10'h354);
      check_idle("reset2");
      rst_i = 1'b0;
      repeat (7) step(10'h354);
      step(10'h100);
      repeat (7) step(10'h354);
      check("broken_run_unlocked", 32'(locked_o), 0);
      step(10'h354);
      check("broken_run_locked", 32'(locked_o), 1);

      // Reset asserted during WAIT returns to SEARCH with cleared counters.
      rst_i = 1'b1;
      step(10'h100);
      rst_i = 1'b0;
      run_to_slip(10'h100, 1100, n);
      check("wait_entry_slip", n, 1024);
      step(10'h100);
      rst_i = 1'b1;
      step(10'h100);
      check_idle("reset_in_wait");
      rst_i = 1'b0;
      run_to_slip(10'h100, 1100, n);
      check("slip_after_wait_reset", n, 1024);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
